// File: rtl/serial_parallel_rx.sv
// Per-lane serial receiver: COM-based byte alignment, lane activation, byte and 32-bit word output.
// Optional macro RX_LSB_FIRST_EN selects LSB-first bit order within each byte.
module serial_parallel_rx #(
    parameter logic [7:0]  COM_BYTE     = 8'hBC,
    parameter int unsigned ACTIVE_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in_serial,
    output logic [7:0]  data_out_8b,
    output logic        valid_out_8b,
    output logic [31:0] data_out_32b,
    output logic        valid_out_32b,
    output logic        active,
    output logic        word_err
);

    typedef enum logic [1:0] {StSearch, StSync, StActive} state_e;

    state_e      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    // Only the three oldest bytes are kept; the fourth comes straight from sr.
    logic [23:0] word_acc_q, word_acc_d;
    logic [7:0]  data8_d;
    logic [31:0] data32_d;
    logic        valid8_d, valid32_d, err_d;
    logic        boundary;
    logic        is_com;

    assign boundary = (bit_cnt_q == 3'd0);
    assign is_com   = (sr_q == COM_BYTE);
    assign active   = (state_q == StActive);

`ifdef RX_LSB_FIRST_EN
    assign sr_d = {data_in_serial, sr_q[7:1]};
`else
    assign sr_d = {sr_q[6:0], data_in_serial};
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        com_cnt_d  = com_cnt_q;
        byte_idx_d = byte_idx_q;
        word_acc_d = word_acc_q;
        data8_d    = data_out_8b;
        data32_d   = data_out_32b;
        valid8_d   = 1'b0;
        valid32_d  = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            StSearch: begin
                if (is_com) begin
                    state_d   = StSync;
                    bit_cnt_d = 3'd1;
                    com_cnt_d = 4'd1;
                end
            end
            StSync: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (int'(com_cnt_q) + 1 == int'(ACTIVE_COUNT)) begin
                            state_d = StActive;
                        end
                    end else begin
                        state_d   = StSearch;
                        com_cnt_d = 4'd0;
                    end
                end
            end
            StActive: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (is_com) begin
                        // Idle mid-word: the partial word can never be completed.
                        if (byte_idx_q != 2'd0) begin
                            err_d = 1'b1;
                        end
                        byte_idx_d = 2'd0;
                        word_acc_d = 24'd0;
                    end else begin
                        data8_d    = sr_q;
                        valid8_d   = 1'b1;
                        word_acc_d = {word_acc_q[15:0], sr_q};
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            data32_d   = {word_acc_q, sr_q};
                            valid32_d  = 1'b1;
                            byte_idx_d = 2'd0;
                        end
                    end
                end
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StSearch;
            sr_q          <= 8'd0;
            bit_cnt_q     <= 3'd0;
            com_cnt_q     <= 4'd0;
            byte_idx_q    <= 2'd0;
            word_acc_q    <= 24'd0;
            data_out_8b   <= 8'd0;
            valid_out_8b  <= 1'b0;
            data_out_32b  <= 32'd0;
            valid_out_32b <= 1'b0;
            word_err      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            com_cnt_q     <= com_cnt_d;
            byte_idx_q    <= byte_idx_d;
            word_acc_q    <= word_acc_d;
            data_out_8b   <= data8_d;
            valid_out_8b  <= valid8_d;
            data_out_32b  <= data32_d;
            valid_out_32b <= valid32_d;
            word_err      <= err_d;
        end
    end

endmodule
